// File: rtl/spi_config_controller.sv
// SPI mode-0 initiator that shifts a 32-bit configuration word out MSB-first with an active-low select.
// Build option: define SPI_CTRL_READBACK_EN to capture the 32 MISO bits into rx_data at each done.
module spi_config_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        sclk,
  output logic        mosi,
  output logic        ss,
  input  logic        miso
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    SCLK_HI = 3'd2,
    SCLK_LO = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  half_q, half_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_q, ss_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        half_zero_s;
  logic        sample_s;
  logic        load_rx_s;

  assign half_zero_s = (half_q == 8'd0);

  // Frame sequencer: every timed state lasts exactly one half-period.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    sample_s  = 1'b0;
    load_rx_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = data_in;
          mosi_d  = data_in[31];
          bit_d   = 6'd0;
          half_d  = HALF_LOAD;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          state_d = SETUP;
        end else begin
          ready_d = 1'b1;
        end
      end
      SETUP: begin
        if (half_zero_s) begin
          half_d   = HALF_LOAD;
          sclk_d   = 1'b1;
          sample_s = 1'b1;
          state_d  = SCLK_HI;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      SCLK_HI: begin
        if (half_zero_s) begin
          half_d = HALF_LOAD;
          sclk_d = 1'b0;
          // The last falling edge leaves mosi on bit 0 through the hold time.
          if (bit_q == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            tx_d    = {tx_q[30:0], 1'b0};
            mosi_d  = tx_q[30];
            bit_d   = bit_q + 6'd1;
            state_d = SCLK_LO;
          end
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      SCLK_LO: begin
        if (half_zero_s) begin
          half_d   = HALF_LOAD;
          sclk_d   = 1'b1;
          sample_s = 1'b1;
          state_d  = SCLK_HI;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      HOLD: begin
        if (half_zero_s) begin
          half_d  = HALF_LOAD;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      GAP: begin
        if (half_zero_s) begin
          half_d    = HALF_LOAD;
          done_d    = 1'b1;
          ready_d   = 1'b1;
          load_rx_s = 1'b1;
          state_d   = IDLE;
        end else begin
          half_d = half_q - 8'd1;
        end
      end
      default: begin
        half_d  = HALF_LOAD;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        ss_d    = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and output registers; reset drops sclk and raises ss without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      half_q  <= HALF_LOAD;
      bit_q   <= 6'd0;
      tx_q    <= 32'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [31:0] rx_sh_q, rx_sh_d;
  logic [31:0] rx_data_q, rx_data_d;

  // MISO is captured as SCLK rises; the word is published together with done.
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    if (sample_s) begin
      rx_sh_d = {rx_sh_q[30:0], miso};
    end else begin
      rx_sh_d = rx_sh_q;
    end
    if (load_rx_s) begin
      rx_data_d = rx_sh_q;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // Readback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_q   <= 32'd0;
      rx_data_q <= 32'd0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`else
  logic unused_rx_s;
  assign unused_rx_s = ^{sample_s, load_rx_s, miso};
  assign rx_data     = 32'd0;
`endif

  assign ready = ready_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign ss    = ss_q;

endmodule

// File: tb/tb_spi_config_controller.sv
// Self-checking bench for spi_config_controller: table of frames at H=4 and H=2 plus reset/back-to-back sequences.
module tb_spi_config_controller;

  logic        clk = 1'b0;
  logic        rst, start, sel, miso;
  logic [31:0] data_in, miso_word;
  logic        start4_s, start2_s;
  logic        ready4, done4, sclk4, mosi4, ss4;
  logic        ready2, done2, sclk2, mosi2, ss2;
  logic [31:0] rx4, rx2;
  logic        ready_s, done_s, sclk_s, mosi_s, ss_s;
  logic [31:0] rx_s;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start4_s = start & ~sel;
  assign start2_s = start & sel;
  assign ready_s  = sel ? ready2 : ready4;
  assign done_s   = sel ? done2  : done4;
  assign sclk_s   = sel ? sclk2  : sclk4;
  assign mosi_s   = sel ? mosi2  : mosi4;
  assign ss_s     = sel ? ss2    : ss4;
  assign rx_s     = sel ? rx2    : rx4;

  spi_config_controller #(.CLK_DIV(4), .FRAME_BITS(32)) dut4 (
    .clk(clk), .rst(rst), .start(start4_s), .data_in(data_in), .ready(ready4), .done(done4),
    .rx_data(rx4), .sclk(sclk4), .mosi(mosi4), .ss(ss4), .miso(miso));

  spi_config_controller #(.CLK_DIV(2), .FRAME_BITS(32)) dut2 (
    .clk(clk), .rst(rst), .start(start2_s), .data_in(data_in), .ready(ready2), .done(done2),
    .rx_data(rx2), .sclk(sclk2), .mosi(mosi2), .ss(ss2), .miso(miso));

  typedef struct {
    logic [31:0] tx;
    logic [31:0] rx;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        sel2;
    logic [31:0] data;
    logic [31:0] mw;
    int          ss_rise;
    int          done_at;
  } vec_t;
  vec_t vecs[5];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rx_f(input logic [31:0] w);
`ifdef SPI_CTRL_READBACK_EN
    return w;
`else
    return 32'd0 & w;
`endif
  endfunction

  // Mode-0 target model: first bit valid on ss fall, next bit after each SCLK fall.
  logic [31:0] slave_sr;
  logic        m_prev_ss, m_prev_sclk;
  initial begin
    miso = 1'b0; slave_sr = 32'd0; m_prev_ss = 1'b1; m_prev_sclk = 1'b0;
    forever begin
      @(ss_s or sclk_s);
      if (!ss_s && m_prev_ss) begin
        slave_sr = miso_word;
        miso = slave_sr[31];
      end else if (!sclk_s && m_prev_sclk && !ss_s) begin
        slave_sr = {slave_sr[30:0], 1'b0};
        miso = slave_sr[31];
      end
      m_prev_ss = ss_s; m_prev_sclk = sclk_s;
    end
  end

  // Monitor and scoreboard.
  int          acc_cyc, rises, ss_fall_rel, ss_rise_rel, done_rel, ss_fall_abs, done_abs, done_count;
  int          rel, h;
  logic [31:0] mosi_word;
  logic        edge_err, prev_sclk, prev_ss;
  sb_t         e;
  initial begin
    acc_cyc = 0; rises = 0; ss_fall_rel = -1; ss_rise_rel = -1; done_rel = -1;
    ss_fall_abs = 0; done_abs = 0; done_count = 0; mosi_word = 32'd0; edge_err = 1'b0;
    prev_sclk = 1'b0; prev_ss = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rel = cyc - acc_cyc;
        h = sel ? 2 : 4;
        if (sclk_s && !prev_sclk) begin
          if (rel != 1 + h + 2 * h * rises) edge_err = 1'b1;
          mosi_word = {mosi_word[30:0], mosi_s};
          rises++;
        end
        if (!ss_s && prev_ss) begin ss_fall_rel = rel; ss_fall_abs = cyc; end
        if (ss_s && !prev_ss) ss_rise_rel = rel;
        if (done_s) begin
          done_rel = rel; done_abs = cyc; done_count++;
          check32("done_has_request", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check32("mosi_word", mosi_word, e.tx);
            check32("rx_data", rx_s, e.rx);
            check32("rise_count", 32'(rises), 32'd32);
            check32("rise_timing_err", 32'(edge_err), 32'd0);
            check32("ready_at_done", 32'(ready_s), 32'd1);
          end
        end
        if (ready_s && start) begin
          acc_cyc = cyc;
          sb_q.push_back('{tx: data_in, rx: exp_rx_f(miso_word)});
          rises = 0; mosi_word = 32'd0; edge_err = 1'b0;
          ss_fall_rel = -1; ss_rise_rel = -1;
        end
      end
      prev_sclk = sclk_s; prev_ss = ss_s;
    end
  end

  task automatic drive_frame(input logic [31:0] d);
    @(posedge clk); #1;
    data_in = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input int budget);
    int n = 0;
    while (done_count < tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check32("done_seen", 32'(done_count >= tgt), 32'd1);
  endtask

  int   tgt, d1, c0;
  logic idle_bad;

  initial begin
    vecs[0] = '{sel2: 1'b0, data: 32'hBBFC_0000, mw: 32'hA5A5_0F0F, ss_rise: 261, done_at: 265};
    vecs[1] = '{sel2: 1'b0, data: 32'h1234_5678, mw: 32'h0F0F_F0F0, ss_rise: 261, done_at: 265};
    vecs[2] = '{sel2: 1'b1, data: 32'hBBFC_0000, mw: 32'hA5A5_0F0F, ss_rise: 131, done_at: 133};
    vecs[3] = '{sel2: 1'b1, data: 32'h8000_0001, mw: 32'hFFFF_FFFF, ss_rise: 131, done_at: 133};
    vecs[4] = '{sel2: 1'b1, data: 32'h0000_0000, mw: 32'h0000_0001, ss_rise: 131, done_at: 133};

    rst = 1'b1; start = 1'b0; sel = 1'b0; data_in = 32'd0; miso_word = 32'd0;
    repeat (3) @(negedge clk);
    check32("rst_ss", 32'(ss_s), 32'd1);
    check32("rst_sclk", 32'(sclk_s), 32'd0);
    check32("rst_mosi", 32'(mosi_s), 32'd0);
    check32("rst_ready", 32'(ready_s), 32'd1);
    check32("rst_done", 32'(done_s), 32'd0);
    check32("rst_rx", rx_s, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    idle_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ss_s !== 1'b1 || sclk_s !== 1'b0 || mosi_s !== 1'b0 || ready_s !== 1'b1 ||
          done_s !== 1'b0 || rx_s !== 32'd0 || ready2 !== 1'b1 || ss2 !== 1'b1) idle_bad = 1'b1;
    end
    check32("idle_stable_bad", 32'(idle_bad), 32'd0);

    for (int i = 0; i < 5; i++) begin
      sel = vecs[i].sel2;
      miso_word = vecs[i].mw;
      tgt = done_count + 1;
      drive_frame(vecs[i].data);
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(tgt, 600);
      check32("ss_fall_cycle", 32'(ss_fall_rel), 32'd1);
      check32("ss_rise_cycle", 32'(ss_rise_rel), 32'(vecs[i].ss_rise));
      check32("done_cycle", 32'(done_rel), 32'(vecs[i].done_at));
      @(negedge clk);
      check32("done_width", 32'(done_s), 32'd0);
    end

    // Back-to-back with start held high.
    sel = 1'b0; miso_word = 32'h5555_AAAA;
    tgt = done_count + 1;
    @(posedge clk); #1 data_in = 32'h0000_0001; start = 1'b1;
    @(posedge clk); #1 data_in = 32'hFFFF_FFFF;
    wait_done(tgt, 600);
    d1 = done_abs;
    @(posedge clk); #1 start = 1'b0;
    wait_done(tgt + 1, 600);
    check32("b2b_ss_fall_after_done", 32'(ss_fall_abs - d1), 32'd1);
    check32("b2b_done_cycle", 32'(done_rel), 32'd265);
    repeat (300) @(negedge clk);
    check32("b2b_frame_count", 32'(done_count), 32'(tgt + 1));

    // Asynchronous reset in the middle of a frame.
    sel = 1'b0; miso_word = 32'h3C3C_5A5A;
    drive_frame(32'hDEAD_BEEF);
    repeat (102) @(negedge clk);
    check32("mid_frame_sclk_high", 32'(sclk_s), 32'd1);
    #2 rst = 1'b1;
    sb_q.delete();
    #1;
    check32("async_ss", 32'(ss_s), 32'd1);
    check32("async_sclk", 32'(sclk_s), 32'd0);
    c0 = done_count;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check32("post_rst_ready", 32'(ready_s), 32'd1);
    check32("post_rst_rx", rx_s, 32'd0);
    repeat (300) @(negedge clk);
    check32("abort_no_done", 32'(done_count - c0), 32'd0);
    tgt = done_count + 1;
    drive_frame(32'h0F1E_2D3C);
    wait_done(tgt, 600);
    check32("fresh_done_cycle", 32'(done_rel), 32'd265);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
